// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register-address width, forwarding-select codes and
// the hazard FSM state encoding.
package pipe_pkg;

   localparam int unsigned REG_AW = 5;

   // Operand-mux select codes; 2'b11 is never produced.
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic {
      StRun     = 1'b0,
      StLuStall = 1'b1
   } hz_state_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source forwarding match: compares one ID source against the EX and MEM
// destinations and picks the youngest producer. x0 never matches.
module fwd_match
   import pipe_pkg::*;
(
   input  logic [REG_AW-1:0] rs,
   input  logic              use_rs,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   output logic              ex_match,
   output logic              mem_match,
   output logic [1:0]        next_sel
);

   assign ex_match  = use_rs && ex_regwrite  && (ex_rd  == rs) && (ex_rd  != '0);
   assign mem_match = use_rs && mem_regwrite && (mem_rd == rs) && (mem_rd != '0);

   // EX producer wins over MEM producer.
   always_comb begin
      next_sel = FWD_REG;
      if (ex_match) begin
         next_sel = FWD_EXMEM;
      end else if (mem_match) begin
         next_sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control: registered operand-mux selects,
// one-cycle load-use stall FSM, taken-branch flush and saturating perf counters.
module hazard_fwd_unit
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic              branch_taken,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
);

   hz_state_t   state_q, state_d;
   logic [1:0]  sel_a_q, sel_a_d;
   logic [1:0]  sel_b_q, sel_b_d;
   logic [15:0] stall_cnt_q, flush_cnt_q;
   logic        stall_inc, flush_inc;

   logic        ex_match_a, mem_match_a, ex_match_b, mem_match_b;
   logic [1:0]  next_sel_a, next_sel_b;
   logic        load_use;

   fwd_match u_fwd_a (
      .rs           (id_rs1),
      .use_rs       (id_use_rs1),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .ex_match     (ex_match_a),
      .mem_match    (mem_match_a),
      .next_sel     (next_sel_a)
   );

   fwd_match u_fwd_b (
      .rs           (id_rs2),
      .use_rs       (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .ex_match     (ex_match_b),
      .mem_match    (mem_match_b),
      .next_sel     (next_sel_b)
   );

   // The EX-match flags already include the use bits.
   assign load_use = ex_memread && (ex_match_a || ex_match_b);

   // Next state, next selects and pipeline controls; branch overrides load-use.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = state_q;
      sel_a_d      = next_sel_a;
      sel_b_d      = next_sel_b;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      if (rst) begin
         state_d = StRun;
      end else if (branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         sel_a_d      = FWD_REG;
         sel_b_d      = FWD_REG;
         state_d      = StRun;
         flush_inc    = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  sel_a_d      = FWD_REG;
                  sel_b_d      = FWD_REG;
                  state_d      = StLuStall;
                  stall_inc    = 1'b1;
               end
            end
            // Load has moved to MEM; selects load normally, detection suppressed.
            StLuStall: begin
               state_d = StRun;
            end
            default: begin
               state_d = StRun;
            end
         endcase
      end
   end

   // State, select and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         sel_a_q     <= FWD_REG;
         sel_b_q     <= FWD_REG;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign fwd_a_sel = sel_a_q;
   assign fwd_b_sel = sel_b_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // A MEM/WB select may only come from a MEM match with no EX match.
   a_memwb_a: assert property (@(posedge clk)
      (next_sel_a == FWD_MEMWB) |-> (mem_match_a && !ex_match_a));
   a_memwb_b: assert property (@(posedge clk)
      (next_sel_b == FWD_MEMWB) |-> (mem_match_b && !ex_match_b));

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit.
module tb_hazard_fwd_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
   logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite;
   logic        branch_taken;
   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [15:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_fwd_unit dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .branch_taken (branch_taken),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .if_id_flush  (if_id_flush),
      .id_ex_bubble (id_ex_bubble),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ins();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      mem_rd = 5'd0; mem_regwrite = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load_use_x3();
      clear_ins();
      ex_rd = 5'd3; ex_regwrite = 1'b1; ex_memread = 1'b1;
      id_rs1 = 5'd1; id_use_rs1 = 1'b1;
      id_rs2 = 5'd3; id_use_rs2 = 1'b1;
   endtask

   initial begin
      clear_ins();
      rst = 1'b1;
      tick();
      tick();
      check("rst_sel_a", 32'(fwd_a_sel), 32'd0);
      check("rst_sel_b", 32'(fwd_b_sel), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      check("rst_pc_write", 32'(pc_write), 32'd1);
      check("rst_bubble", 32'(id_ex_bubble), 32'd0);
      rst = 1'b0;

      // EX writes x5, ID reads x5 as rs1.
      clear_ins();
      ex_rd = 5'd5; ex_regwrite = 1'b1;
      id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd6; id_use_rs2 = 1'b1;
      #1;
      check("ex_fwd_pc_write", 32'(pc_write), 32'd1);
      check("ex_fwd_bubble", 32'(id_ex_bubble), 32'd0);
      tick();
      check("ex_fwd_sel_a", 32'(fwd_a_sel), 32'd1);
      check("ex_fwd_sel_b", 32'(fwd_b_sel), 32'd0);

      // EX and MEM both write x7: youngest wins.
      clear_ins();
      ex_rd = 5'd7; ex_regwrite = 1'b1; mem_rd = 5'd7; mem_regwrite = 1'b1;
      id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
      tick();
      check("prio_sel_a", 32'(fwd_a_sel), 32'd1);
      check("prio_sel_b", 32'(fwd_b_sel), 32'd1);

      // MEM-only producer; rs2 matches but is not used.
      clear_ins();
      mem_rd = 5'd9; mem_regwrite = 1'b1;
      id_rs1 = 5'd9; id_use_rs1 = 1'b1; id_rs2 = 5'd9; id_use_rs2 = 1'b0;
      tick();
      check("mem_sel_a", 32'(fwd_a_sel), 32'd2);
      check("mem_unused_sel_b", 32'(fwd_b_sel), 32'd0);

      // Load-use on rs2: one stall cycle, then MEM/WB forward.
      load_use_x3();
      #1;
      check("lu_pc_write", 32'(pc_write), 32'd0);
      check("lu_if_id_write", 32'(if_id_write), 32'd0);
      check("lu_bubble", 32'(id_ex_bubble), 32'd1);
      check("lu_flush", 32'(if_id_flush), 32'd0);
      tick();
      check("lu_sel_a", 32'(fwd_a_sel), 32'd0);
      check("lu_sel_b", 32'(fwd_b_sel), 32'd0);
      check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      mem_rd = 5'd3; mem_regwrite = 1'b1;
      #1;
      check("lus_pc_write", 32'(pc_write), 32'd1);
      check("lus_if_id_write", 32'(if_id_write), 32'd1);
      check("lus_bubble", 32'(id_ex_bubble), 32'd0);
      tick();
      check("lus_sel_b", 32'(fwd_b_sel), 32'd2);
      check("lus_stall_cnt", 32'(stall_cnt), 32'd1);

      // Load-use together with a taken branch: branch wins.
      clear_ins();
      do_reset();
      load_use_x3();
      branch_taken = 1'b1;
      #1;
      check("br_flush", 32'(if_id_flush), 32'd1);
      check("br_bubble", 32'(id_ex_bubble), 32'd1);
      check("br_pc_write", 32'(pc_write), 32'd1);
      tick();
      check("br_flush_cnt", 32'(flush_cnt), 32'd1);
      check("br_stall_cnt", 32'(stall_cnt), 32'd0);
      check("br_sel_b", 32'(fwd_b_sel), 32'd0);

      // x0 is never forwarded.
      clear_ins();
      ex_rd = 5'd0; ex_regwrite = 1'b1; mem_rd = 5'd0; mem_regwrite = 1'b1;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      tick();
      check("x0_sel_a", 32'(fwd_a_sel), 32'd0);
      check("x0_sel_b", 32'(fwd_b_sel), 32'd0);

      // Reset during the stall abandons it.
      load_use_x3();
      tick();
      rst = 1'b1;
      #1;
      check("rstlu_pc_write", 32'(pc_write), 32'd1);
      check("rstlu_bubble", 32'(id_ex_bubble), 32'd0);
      tick();
      rst = 1'b0;
      clear_ins();
      #1;
      check("post_rst_pc_write", 32'(pc_write), 32'd1);
      check("post_rst_bubble", 32'(id_ex_bubble), 32'd0);
      check("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("post_rst_flush_cnt", 32'(flush_cnt), 32'd0);
      // State must be RUN: a fresh load-use stalls immediately.
      load_use_x3();
      #1;
      check("post_rst_run_stall", 32'(pc_write), 32'd0);
      tick();
      clear_ins();
      tick();

      // Flush counter saturation.
      do_reset();
      branch_taken = 1'b1;
      repeat (65535) tick();
      check("flush_sat_edge", 32'(flush_cnt), 32'hFFFF);
      repeat (5) tick();
      check("flush_sat_hold", 32'(flush_cnt), 32'hFFFF);
      branch_taken = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
